max_unpooling_mult: RTL and testbench

- 2x2 stride-2 unpooling: the inverse of the row-pair max-pooling stage.
- Accepts one pooled row of W/2 pixels (D channels each) per transfer and emits two full-width rows of W pixels on consecutive output beats.
- Two modes, both with valid/ready handshake on both sides:
  - nearest-neighbour replicate;
  - indexed, driven by 2-bit argmax switches per pooled pixel.
- Sits in the decoder/upsampling path, feeding the next conv row buffer.

---
 rtl/max_unpooling_mult_if.sv | 26 ++
 rtl/max_unpooling_mult.sv | 135 +++++++++++++
 tb/tb_max_unpooling_mult.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_unpooling_mult_if.sv
// Row-level handshake bundle for the 2x2 max-unpooling stage.
// It carries the pooled input row and the full-width output row, each with valid/ready.
interface max_unpooling_mult_if #(
  parameter int DATA_BITS = 8,
  parameter int D         = 1,
  parameter int W         = 24
) ();
  logic                          valid_i;
  logic                          ready_o;
  logic [(W/2)*D*DATA_BITS-1:0]  multi_input_data;
  logic [(W/2)*2-1:0]            idx_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [W*D*DATA_BITS-1:0]      multi_output_data;
  logic                          last_o;

  modport master (
    output valid_i, multi_input_data, idx_i, ready_i,
    input  ready_o, valid_o, multi_output_data, last_o
  );

  modport slave (
    input  valid_i, multi_input_data, idx_i, ready_i,
    output ready_o, valid_o, multi_output_data, last_o
  );
endinterface

// File: rtl/max_unpooling_mult.sv
// 2x2 stride-2 unpooling: each pooled row is expanded into a top and a bottom full-width row,
// either by replication (MODE=0) or by argmax switches with zero fill (MODE=1).
module max_unpooling_mult #(
  parameter int DATA_BITS = 8,
  parameter int D         = 1,
  parameter int H         = 24,
  parameter int W         = 24,
  parameter int MODE      = 0
) (
  input  logic               clk,
  input  logic               reset,
  max_unpooling_mult_if.slave bus
);
  localparam int PIX_W = D * DATA_BITS;
  localparam int IN_W  = (W / 2) * PIX_W;
  localparam int IDX_W = (W / 2) * 2;
  localparam int OUT_W = W * PIX_W;
  localparam int ROWS  = H / 2;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TOP  = 2'd1,
    BOT  = 2'd2
  } state_e;

  state_e             state_q;
  logic [IN_W-1:0]    data_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   row_cnt_q;
  logic [OUT_W-1:0]   out_q;
  logic               valid_q;
  logic               last_q;

  logic               ready_s;
  logic               in_fire_s;
  logic [OUT_W-1:0]   top_row_d;
  logic [OUT_W-1:0]   bot_row_d;
  logic [CNT_W-1:0]   row_cnt_d;

  // Output pixel k takes pooled pixel k>>1; in indexed mode only the switch-selected slot keeps it.
  function automatic logic [OUT_W-1:0] expand_row(input logic [IN_W-1:0]  data,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic             r);
    logic [OUT_W-1:0] row;
    row = '0;
    for (int k = 0; k < W; k++) begin
      if ((MODE == 0) || (idx[2*(k/2) +: 2] == {r, k[0]})) begin
        row[k*PIX_W +: PIX_W] = data[(k/2)*PIX_W +: PIX_W];
      end else begin
        row[k*PIX_W +: PIX_W] = '0;
      end
    end
    return row;
  endfunction

  assign top_row_d = expand_row(bus.multi_input_data, bus.idx_i, 1'b0);
  assign bot_row_d = expand_row(data_q, idx_q, 1'b1);
  assign row_cnt_d = (row_cnt_q == CNT_LAST) ? '0 : row_cnt_q + CNT_W'(1);
  assign in_fire_s = bus.valid_i & ready_s;

  // The BOT beat frees the buffer, so the next row may be taken in the same cycle it drains.
  always_comb begin
    ready_s = 1'b0;
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      case (state_q)
        IDLE:    ready_s = 1'b1;
        BOT:     ready_s = bus.ready_i;
        default: ready_s = 1'b0;
      endcase
    end
  end

  // Row FSM; the output row is precomputed into out_q so nothing downstream sees the input bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      row_cnt_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire_s) begin
            data_q  <= bus.multi_input_data;
            idx_q   <= bus.idx_i;
            out_q   <= top_row_d;
            valid_q <= 1'b1;
            state_q <= TOP;
          end
        end
        TOP: begin
          if (bus.ready_i) begin
            out_q   <= bot_row_d;
            last_q  <= (row_cnt_q == CNT_LAST);
            state_q <= BOT;
          end
        end
        BOT: begin
          if (bus.ready_i) begin
            row_cnt_q <= row_cnt_d;
            last_q    <= 1'b0;
            if (bus.valid_i) begin
              data_q  <= bus.multi_input_data;
              idx_q   <= bus.idx_i;
              out_q   <= top_row_d;
              state_q <= TOP;
            end else begin
              out_q   <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          out_q   <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o           = ready_s;
  assign bus.valid_o           = valid_q;
  assign bus.multi_output_data = out_q;
  assign bus.last_o            = last_q;
endmodule

// File: tb/tb_max_unpooling_mult.sv
// Bench for max_unpooling_mult: W=4, H=4, D=1, 8-bit pixels, one replicate and one indexed instance
// driven with identical stimulus and checked against a beat-queue reference model.
module tb_max_unpooling_mult;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int ROWS = H / 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_i;
  logic [15:0] din;
  logic [3:0]  idx;

  int errors = 0;
  int checks = 0;

  // Expected beats per instance: bit 32 marks a bottom row.
  typedef logic [32:0] beat_t;
  beat_t exp_q [2][$];
  int    rows_out [2];

  typedef struct {
    logic [15:0] din;
    logic [3:0]  idx;
    logic [31:0] e0;
    logic [31:0] e1t;
    logic [31:0] e1b;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  max_unpooling_mult_if #(.DATA_BITS(8), .D(1), .W(W)) if0 ();
  max_unpooling_mult_if #(.DATA_BITS(8), .D(1), .W(W)) if1 ();

  assign if0.valid_i = valid_i;
  assign if0.ready_i = ready_i;
  assign if0.multi_input_data = din;
  assign if0.idx_i = idx;
  assign if1.valid_i = valid_i;
  assign if1.ready_i = ready_i;
  assign if1.multi_input_data = din;
  assign if1.idx_i = idx;

  max_unpooling_mult #(.DATA_BITS(8), .D(1), .H(H), .W(W), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  max_unpooling_mult #(.DATA_BITS(8), .D(1), .H(H), .W(W), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  function automatic logic [31:0] exp_row(input logic [15:0] d, input logic [3:0] ix,
                                          input int mode, input int r);
    logic [31:0] row;
    int          j;
    int          c;
    row = '0;
    for (int k = 0; k < W; k++) begin
      j = k / 2;
      c = k % 2;
      if (mode == 0 || int'(ix[2*j +: 2]) == r * 2 + c) row[k*8 +: 8] = d[j*8 +: 8];
    end
    return row;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_one(input int m, input logic v, input logic r, input logic [31:0] d,
                         input logic l);
    beat_t f;
    int    n;
    logic  er;
    logic  el;
    if (reset) begin
      exp_q[m].delete();
      rows_out[m] = 0;
      return;
    end
    n  = exp_q[m].size();
    er = (n == 0) || (n == 1 && ready_i);
    check($sformatf("m%0d valid_o", m), 32'(v), 32'(n > 0));
    check($sformatf("m%0d ready_o", m), 32'(r), 32'(er));
    if (n > 0) begin
      f  = exp_q[m][0];
      el = f[32] && (rows_out[m] % ROWS == ROWS - 1);
      check($sformatf("m%0d data", m), d, f[31:0]);
      check($sformatf("m%0d last_o", m), 32'(l), 32'(el));
      if (ready_i) begin
        if (f[32]) rows_out[m]++;
        void'(exp_q[m].pop_front());
      end
    end else begin
      check($sformatf("m%0d last_o idle", m), 32'(l), 32'd0);
    end
    if (valid_i && er) begin
      exp_q[m].push_back({1'b0, exp_row(din, idx, m, 0)});
      exp_q[m].push_back({1'b1, exp_row(din, idx, m, 1)});
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon_one(0, if0.valid_o, if0.ready_o, if0.multi_output_data, if0.last_o);
    mon_one(1, if1.valid_o, if1.ready_o, if1.multi_output_data, if1.last_o);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample();
    advance();
    reset = 1'b0;
  endtask

  task automatic stream_rows(input int n, input logic [31:0] exp_mask, input string tag);
    int          beats;
    int          sent;
    logic [31:0] lmask;
    beats   = 0;
    sent    = 0;
    lmask   = '0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    din     = 16'($urandom);
    idx     = 4'($urandom);
    for (int c = 0; c <= 2 * n; c++) begin
      sample();
      if (if0.valid_o && ready_i) begin
        beats++;
        if (if0.last_o) lmask[beats] = 1'b1;
      end
      advance();
      if (c % 2 == 0 && sent < n) begin
        sent++;
        if (sent == n) valid_i = 1'b0;
        else begin
          din = 16'($urandom);
          idx = 4'($urandom);
        end
      end
    end
    check({tag, " beats"}, 32'(beats), 32'(2 * n));
    check({tag, " last mask"}, lmask, exp_mask);
  endtask

  initial begin
    vecs[0] = '{din: 16'h2211, idx: 4'b1001, e0: 32'h22221111, e1t: 32'h00001100, e1b: 32'h00220000};
    vecs[1] = '{din: 16'hA53C, idx: 4'b0011, e0: 32'hA5A53C3C, e1t: 32'h00A50000, e1b: 32'h00003C00};
    vecs[2] = '{din: 16'hFF00, idx: 4'b0110, e0: 32'hFFFF0000, e1t: 32'hFF000000, e1b: 32'h00000000};
    vecs[3] = '{din: 16'h8001, idx: 4'b1100, e0: 32'h80800101, e1t: 32'h00000001, e1b: 32'h80000000};

    // Reset with valid_i and ready_i asserted: nothing may be consumed or emitted.
    reset   = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b1;
    din     = 16'h5A5A;
    idx     = 4'b1111;
    advance();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rst valid_o", 32'(if0.valid_o | if1.valid_o), 32'd0);
      check("rst ready_o", 32'(if0.ready_o | if1.ready_o), 32'd0);
      check("rst data0", if0.multi_output_data, 32'd0);
      check("rst data1", if1.multi_output_data, 32'd0);
      advance();
    end
    reset   = 1'b0;
    valid_i = 1'b0;
    sample();
    check("post-rst ready_o", 32'(if0.ready_o & if1.ready_o), 32'd1);
    advance();

    // Table-driven single rows: top beat, bottom beat, then idle.
    for (int v = 0; v < 4; v++) begin
      valid_i = 1'b1;
      din     = vecs[v].din;
      idx     = vecs[v].idx;
      sample();
      advance();
      valid_i = 1'b0;
      sample();
      check($sformatf("vec%0d top m0", v), if0.multi_output_data, vecs[v].e0);
      check($sformatf("vec%0d top m1", v), if1.multi_output_data, vecs[v].e1t);
      advance();
      sample();
      check($sformatf("vec%0d bot m0", v), if0.multi_output_data, vecs[v].e0);
      check($sformatf("vec%0d bot m1", v), if1.multi_output_data, vecs[v].e1b);
      advance();
      sample();
      check($sformatf("vec%0d idle", v), 32'(if0.valid_o | if1.valid_o), 32'd0);
      advance();
    end

    // Backpressure in TOP while a second row waits upstream.
    valid_i = 1'b1;
    din     = vecs[0].din;
    idx     = vecs[0].idx;
    sample();
    advance();
    din     = vecs[1].din;
    idx     = vecs[1].idx;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp top hold m1", if1.multi_output_data, vecs[0].e1t);
      check("bp ready_o", 32'(if0.ready_o | if1.ready_o), 32'd0);
      advance();
    end
    ready_i = 1'b1;
    sample();
    advance();
    sample();
    check("bp bot m1", if1.multi_output_data, vecs[0].e1b);
    check("bp bot ready_o", 32'(if1.ready_o), 32'd1);
    advance();
    valid_i = 1'b0;
    sample();
    check("bp new top m1", if1.multi_output_data, vecs[1].e1t);
    advance();
    sample();
    check("bp new bot m1", if1.multi_output_data, vecs[1].e1b);
    advance();

    // Full frame back-to-back: last_o on beats 4 and 8 only.
    do_reset();
    stream_rows(4, 32'h0000_0110, "stream");

    // Reset while in BOT with a row offered upstream.
    valid_i = 1'b1;
    din     = 16'h1234;
    idx     = 4'b0101;
    sample();
    advance();
    din = 16'h4321;
    sample();
    advance();
    reset = 1'b1;
    sample();
    advance();
    reset   = 1'b0;
    valid_i = 1'b0;
    sample();
    check("bot-rst valid_o", 32'(if0.valid_o | if1.valid_o), 32'd0);
    check("bot-rst ready_o", 32'(if0.ready_o & if1.ready_o), 32'd1);
    advance();
    stream_rows(4, 32'h0000_0110, "post-rst stream");

    // Random traffic with occasional resets, checked by the beat-queue model.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 149) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      din     = 16'($urandom);
      idx     = 4'($urandom);
      sample();
      advance();
    end
    reset   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
